brick_hit_reporter: RTL and testbench

Converts pixel-level shell-versus-brick overlaps from the VGA draw path into single, debounced brick-coordinate hit reports for the brick-matrix owner. It sits between the object draw muxing (shell and brick drawing requests) and the brick matrix, driving its `brickCollision1X/Y` and `collision` inputs. It guarantees the receiver sees exactly one clean high-then-low `collision` episode per accepted hit, with stable coordinates.

---
 rtl/brick_hit_reporter_if.sv | 10 +
 rtl/brick_hit_reporter.sv | 89 ++++++++
 tb/tb_brick_hit_reporter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/brick_hit_reporter_if.sv
// brick_hit_reporter_if: hit report bus from the reporter to the brick-matrix owner and shell controller.
interface brick_hit_reporter_if;
  logic [4:0] brickCollisionX;
  logic [3:0] brickCollisionY;
  logic       collision;
  logic       shellHit;
  logic       busy;
  modport master (output brickCollisionX, brickCollisionY, collision, shellHit, busy);
  modport slave (input brickCollisionX, brickCollisionY, collision, shellHit, busy);
endinterface

// File: rtl/brick_hit_reporter.sv
// brick_hit_reporter: turns pixel-level shell/brick overlaps into one debounced brick-coordinate hit report.
module brick_hit_reporter #(
  parameter int BLOCK_WIDTH = 32,
  parameter int BLOCK_HEIGHT = 32,
  parameter int BLOCKS_PER_ROW = 17,
  parameter int BLOCKS_PER_COLUMN = 14,
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic shellDrawingRequest,
  input  logic brickDrawingRequest,
  input  logic [BLOCKS_PER_COLUMN-1:0][BLOCKS_PER_ROW-1:0] matrix,
  brick_hit_reporter_if.master rpt
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, LATCH, CHECK, ASSERT, RELEASE} state_t;
  state_t state_q;
  logic [4:0] x_q;
  logic [3:0] y_q;
  logic coll_q, shell_hit_q, busy_q, hit_q, hit_d, accept_d;
  logic [CW-1:0] cnt_q;
  logic [10:0] dx_d, dy_d, col_d, row_d;
  // a frame start clears the flag before the coincident candidate is judged
  always_comb begin
    dx_d = pixelX - topLeftX;
    dy_d = pixelY - topLeftY;
    col_d = dx_d >> $clog2(BLOCK_WIDTH);
    row_d = dy_d >> $clog2(BLOCK_HEIGHT);
    hit_d = hit_q && !startOfFrame;
    accept_d = state_q == IDLE && shellDrawingRequest && brickDrawingRequest && !hit_d &&
               pixelX >= topLeftX && pixelY >= topLeftY &&
               col_d < 11'(BLOCKS_PER_ROW) && row_d < 11'(BLOCKS_PER_COLUMN);
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      coll_q <= 1'b0;
      shell_hit_q <= 1'b0;
      busy_q <= 1'b0;
      hit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hit_q <= hit_d;
      shell_hit_q <= 1'b0;
      case (state_q)
        IDLE: if (accept_d) begin
          state_q <= LATCH;
          x_q <= col_d[4:0];
          y_q <= row_d[3:0];
          busy_q <= 1'b1;
          hit_q <= 1'b1;
        end
        LATCH: state_q <= CHECK;
        CHECK: if (matrix[y_q][x_q]) begin
          state_q <= ASSERT;
          coll_q <= 1'b1;
          shell_hit_q <= 1'b1;
          cnt_q <= CW'(HOLD_CYCLES - 1);
        end else begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          hit_q <= 1'b0;
        end
        ASSERT: if (cnt_q == '0) begin
          state_q <= RELEASE;
          coll_q <= 1'b0;
        end else cnt_q <= cnt_q - 1'b1;
        RELEASE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rpt.brickCollisionX = x_q;
  assign rpt.brickCollisionY = y_q;
  assign rpt.collision = coll_q;
  assign rpt.shellHit = shell_hit_q;
  assign rpt.busy = busy_q;
endmodule

// File: tb/tb_brick_hit_reporter.sv
// tb_brick_hit_reporter: directed and random overlaps checked against a frame-level hit model via a report scoreboard.
module tb_brick_hit_reporter;
  localparam int HOLD = 2, BW = 32, BH = 32, BPR = 17, BPC = 14;
  typedef struct {int x; int y; int cyc;} exp_t;
  logic clk = 0, resetN = 0, sof = 0, sh = 0, br = 0;
  logic [10:0] px = 0, py = 0, tx = 0, ty = 0;
  logic [13:0][16:0] mat = '0, mat_next = '0;
  int cyc = 0, errors = 0, checks = 0;
  bit flag = 0;
  int free_at = 0, pend_e = -1, pc = 0, pr = 0, bf = 0, bt = -1;
  exp_t q[$];
  exp_t ex;
  logic prev = 0;
  int run = 0;
  brick_hit_reporter_if rpt();
  brick_hit_reporter #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .topLeftX(tx), .topLeftY(ty), .shellDrawingRequest(sh), .brickDrawingRequest(br),
    .matrix(mat), .rpt(rpt)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cyc %0d: got=%0d expected=%0d", n, cyc, got, want);
    end
  endtask
  // one cycle of stimulus; the model judges it against the edge that will sample it
  task automatic step(input int x, input int y, input int lx, input int ly, input bit s, input bit b, input bit f);
    int e;
    @(negedge clk);
    mat = mat_next;
    px = 11'(x); py = 11'(y); tx = 11'(lx); ty = 11'(ly);
    sh = s; br = b; sof = f;
    e = cyc + 1;
    if (pend_e == e) begin
      if (mat[pr][pc]) begin
        q.push_back('{pc, pr, e});
        free_at = e + HOLD + 2;
        bt = e + HOLD;
      end else flag = 0;
      pend_e = -1;
    end
    if (f) flag = 0;
    if (s && b && !flag && e >= free_at && x >= lx && y >= ly && (x - lx) / BW < BPR && (y - ly) / BH < BPC) begin
      flag = 1;
      pc = (x - lx) / BW;
      pr = (y - ly) / BH;
      pend_e = e + 2;
      free_at = e + 3;
      bf = e;
      bt = e + 1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (!resetN) begin
      prev = 0;
      run = 0;
    end else begin
      chk("busy", int'(rpt.busy), int'(cyc >= bf && cyc <= bt));
      if (rpt.collision && !prev) begin
        if (q.size() == 0) chk("unexpected_report", 1, 0);
        else begin
          ex = q.pop_front();
          chk("report_x", int'(rpt.brickCollisionX), ex.x);
          chk("report_y", int'(rpt.brickCollisionY), ex.y);
          chk("report_cycle", cyc, ex.cyc);
          chk("shellhit_first", int'(rpt.shellHit), 1);
        end
      end else if (rpt.shellHit) chk("shellhit_stray", 1, 0);
      if (rpt.collision) run++;
      else if (prev) begin
        chk("hold_len", run, HOLD);
        run = 0;
      end
      prev = rpt.collision;
    end
  end
  initial begin
    int x, y, lx, ly;
    bit s, b, f;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_x", int'(rpt.brickCollisionX), 0);
    chk("rst_y", int'(rpt.brickCollisionY), 0);
    chk("rst_coll", int'(rpt.collision), 0);
    chk("rst_shellhit", int'(rpt.shellHit), 0);
    chk("rst_busy", int'(rpt.busy), 0);
    resetN = 1;
    idle(2);
    mat_next[2][3] = 1;
    step(100, 70, 0, 0, 1, 1, 0);
    idle(1);
    #1;
    chk("latch_x", int'(rpt.brickCollisionX), 3);
    chk("latch_y", int'(rpt.brickCollisionY), 2);
    idle(8);
    mat_next[2][6] = 1;
    step(200, 70, 0, 0, 1, 1, 0);
    idle(8);
    step(0, 0, 0, 0, 0, 0, 1);
    step(200, 70, 0, 0, 1, 1, 0);
    idle(8);
    step(200, 70, 0, 0, 1, 1, 1);
    idle(8);
    mat_next[2][3] = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(100, 70, 0, 0, 1, 1, 0);
    idle(2);
    mat_next[1][1] = 1;
    step(40, 40, 0, 0, 1, 1, 0);
    idle(8);
    step(0, 0, 0, 0, 0, 0, 1);
    step(20, 50, 32, 32, 1, 1, 0);
    idle(3);
    step(600, 10, 0, 0, 1, 1, 0);
    idle(3);
    mat_next[13][16] = 1;
    step(543, 447, 0, 0, 1, 1, 0);
    idle(8);
    mat_next[2][3] = 1;
    step(0, 0, 0, 0, 0, 0, 1);
    step(100, 70, 0, 0, 1, 1, 0);
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1 resetN = 0;
    #1;
    chk("arst_x", int'(rpt.brickCollisionX), 0);
    chk("arst_y", int'(rpt.brickCollisionY), 0);
    chk("arst_coll", int'(rpt.collision), 0);
    chk("arst_shellhit", int'(rpt.shellHit), 0);
    chk("arst_busy", int'(rpt.busy), 0);
    flag = 0; free_at = 0; pend_e = -1; bf = 0; bt = -1;
    q.delete();
    idle(2);
    resetN = 1;
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0)
        for (int r = 0; r < BPC; r++)
          for (int c = 0; c < BPR; c++) mat_next[r][c] = 1'($urandom_range(1));
      lx = ($urandom_range(3) == 0) ? int'($urandom_range(100)) : 0;
      ly = ($urandom_range(3) == 0) ? int'($urandom_range(100)) : 0;
      x = int'($urandom_range(700));
      y = int'($urandom_range(500));
      s = $urandom_range(3) != 0;
      b = $urandom_range(3) != 0;
      f = $urandom_range(39) == 0;
      step(x, y, lx, ly, s, b, f);
    end
    idle(10);
    chk("reports_outstanding", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
